fxp_seq_mul: RTL and testbench

- Sequential radix-2 shift-and-add multiplier for unsigned Q2.(WIDTH-2) fixed-point operands. This is the same number format the iterative divider datapath uses.
- It is the inverse operation of the divider. It recombines quotient × denominator so the result can be compared with the original numerator, and it serves as a shared low-area multiplier for normalisation and scaling steps.
- Valid/ready handshake on input and output. One operation in flight at a time.

---
 rtl/fxp_seq_mul.sv | 121 ++++++++++++
 tb/tb_fxp_seq_mul.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fxp_seq_mul.sv
// fxp_seq_mul: radix-2 shift-and-add multiplier for unsigned Q2.(WIDTH-2).
// One operation in flight; valid/ready on both sides; product saturates on overflow.
module fxp_seq_mul #(
    parameter int WIDTH = 29
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product,
    output logic             ovf
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PW-1:0]    a_reg;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    acc_nxt;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] prod_nxt;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             ovf_nxt;

    assign last = (cnt == CW'(WIDTH - 1));

    // Accumulator after this iteration's conditional add, and the
    // saturated Q2 result that would be formed from it.
    always_comb begin
        acc_nxt  = acc + (b_reg[0] ? a_reg : '0);
        ovf_nxt  = |acc_nxt[PW-1:PW-2];
        prod_nxt = ovf_nxt ? '1 : acc_nxt[PW-3:WIDTH-2];
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, shift-and-add iterations and result registration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
            ovf     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= {{WIDTH{1'b0}}, a};
                        b_reg <= b;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc   <= acc_nxt;
                    a_reg <= a_reg << 1;
                    b_reg <= b_reg >> 1;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        product <= prod_nxt;
                        ovf     <= ovf_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fxp_seq_mul.sv
// tb_fxp_seq_mul: directed and random checks of fxp_seq_mul (WIDTH = 29)
// against an arithmetic reference model of the Q2.27 product.
module tb_fxp_seq_mul;

    localparam int W = 29;
    localparam logic [W-1:0] MASK = '1;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] product;
    logic         ovf;

    int checks;
    int errors;

    fxp_seq_mul #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Real-number rule: value = a*b / 2^54; overflow when >= 4.0;
    // otherwise keep 27 fractional bits, truncating.
    task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv,
                         output logic [W-1:0] p, output logic o);
        longint unsigned full;
        full = longint'(av) * longint'(bv);
        o    = (full >= (64'd1 << 56));
        p    = o ? MASK : W'(full / (64'd1 << 27));
    endtask

    // Present operands for one accept edge.
    task automatic start(input logic [W-1:0] av, input logic [W-1:0] bv);
        chk("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("in_ready_after_accept", in_ready, 0);
    endtask

    // Wait for out_valid (inputs scribbled meanwhile), check latency and
    // result, then complete the output handshake.
    task automatic finish_op(input string tag, input logic [W-1:0] av,
                             input logic [W-1:0] bv, output logic [W-1:0] got);
        logic [W-1:0] ep;
        logic         eo;
        int           n;
        n = 0;
        while (out_valid !== 1'b1 && n < W + 8) begin
            in_valid = 1'($urandom);
            a        = W'($urandom);
            b        = W'($urandom);
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        model(av, bv, ep, eo);
        chk({tag, "_latency"}, 64'(n), 64'(W));
        chk({tag, "_product"}, product, ep);
        chk({tag, "_ovf"}, ovf, eo);
        chk({tag, "_no_in_ready_in_done"}, in_ready, 0);
        got       = product;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_out_valid_dropped"}, out_valid, 0);
        chk({tag, "_product_held_idle"}, product, ep);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] av,
                          input logic [W-1:0] bv, output logic [W-1:0] got);
        start(av, bv);
        finish_op(tag, av, bv, got);
    endtask

    initial begin
        logic [W-1:0] got;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] q;
        longint       d;

        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_product", product, 0);
        chk("rst_ovf", ovf, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Leave a nonzero held result, then abort the next op mid-RUN.
        run_op("one_p5_sq", W'(32'h0C00_0000), W'(32'h0C00_0000), got);
        chk("one_p5_sq_const", got, W'(32'h1200_0000));
        start(W'(32'h1234_5678), W'(32'h0ABC_DEF1));
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_product", product, 0);
        chk("abort_ovf", ovf, 0);
        chk("abort_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_still_idle", in_ready, 1);

        run_op("one_sq", W'(32'h0800_0000), W'(32'h0800_0000), got);
        chk("one_sq_const", got, W'(32'h0800_0000));
        run_op("three_x_1p", W'(32'h1800_0000), W'(32'h0800_0001), got);
        run_op("three_sq", W'(32'h1800_0000), W'(32'h1800_0000), got);
        chk("three_sq_sat", got, W'(32'h1FFF_FFFF));
        run_op("two_sq_edge", W'(32'h1000_0000), W'(32'h1000_0000), got);
        chk("two_sq_sat", got, W'(32'h1FFF_FFFF));
        run_op("max_x_one", MASK, W'(32'h0800_0000), got);
        chk("max_x_one_const", got, MASK);
        run_op("lsb_sq", W'(1), W'(1), got);
        chk("lsb_sq_zero", got, 0);
        run_op("zero_a", '0, W'($urandom), got);
        run_op("zero_b", W'($urandom), '0, got);

        // Backpressure with ignored in_valid pulses.
        start(W'(32'h0A5A_5A5A), W'(32'h0933_3333));
        finish_op_wait_only: begin
            int n;
            n = 0;
            while (out_valid !== 1'b1 && n < W + 8) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("bp_latency", 64'(n), 64'(W));
        end
        model(W'(32'h0A5A_5A5A), W'(32'h0933_3333), ra, rb[0]);
        for (int i = 0; i < 50; i++) begin
            in_valid = 1'(i & 1);
            a        = W'($urandom);
            b        = W'($urandom);
            @(posedge clk);
            #1;
            if (i % 10 == 9) begin
                chk("bp_product_stable", product, ra);
                chk("bp_out_valid", out_valid, 1);
                chk("bp_in_ready_low", in_ready, 0);
            end
        end
        chk("bp_ovf_stable", ovf, rb[0]);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a         = W'(32'h0600_0000);
        b         = W'(32'h0C00_0000);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_idle_after_handshake", in_ready, 1);
        chk("bp_out_valid_low", out_valid, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_accept_next_cycle", in_ready, 0);
        finish_op("bp_next", W'(32'h0600_0000), W'(32'h0C00_0000), got);

        // Round trip with a truncated quotient 10/14 in Q2.27.
        q = W'((64'h0A00_0000 << 27) / 64'h0E00_0000);
        run_op("roundtrip", q, W'(32'h0E00_0000), got);
        d = 64'sh0A00_0000 - longint'(got);
        chk("roundtrip_within_4lsb", (d >= 0 && d <= 4), 1);

        for (int i = 0; i < 16; i++) begin
            ra = W'($urandom);
            rb = (i < 8) ? W'($urandom_range(0, 32'h0FFF_FFFF)) : W'($urandom);
            run_op("rand", ra, rb, got);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
